// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read-channel responder (AR/R) backed by a DEPTH-word register array.
// One outstanding read, fixed programmable latency, SLVERR for out-of-range addresses.
// The array is loaded through a byte-masked local write port that works in any state.
module axi_lite_read_slave #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned IW     = $clog2(DEPTH)
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          ARVALID,
  input  logic [31:0]   ARADDR,
  output logic          ARREADY,
  output logic          RVALID,
  output logic [31:0]   RDATA,
  output logic [1:0]    RRESP,
  input  logic          RREADY,
  input  logic          lw_en,
  input  logic [IW-1:0] lw_addr,
  input  logic [31:0]   lw_data,
  input  logic [3:0]    lw_strb,
  output logic          busy,
  output logic [15:0]   rd_count
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  // Wait-counter start value; only used when RD_LAT > 0.
  localparam logic [3:0] LatInit = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [IW-1:0] idx_q;
  logic          err_q;
  logic          arready_q;
  logic          rvalid_q;
  logic          busy_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [15:0]   rd_count_q;
  logic [31:0]   mem_q [DEPTH];

  logic [IW-1:0] ar_idx;
  logic          ar_err;
  logic          ar_hs;
  logic          r_hs;
  logic [IW-1:0] cap_idx;
  logic          cap_err;
  logic [31:0]   cap_data;
  logic          unused_addr_lsb;

  // Byte offset is ignored: reads are word-aligned down.
  assign unused_addr_lsb = ^ARADDR[1:0];
  assign ar_idx = ARADDR[IW+1:2];
  // Any set bit above the index field means the address is past the array (no wrap).
  assign ar_err = |ARADDR[31:IW+2];
  assign ar_hs  = ARVALID && arready_q;
  assign r_hs   = rvalid_q && RREADY;

  // With zero latency the response is captured on the AR handshake edge itself,
  // so the index comes straight from the bus rather than the latched copy.
  assign cap_idx  = (RD_LAT == 0) ? ar_idx : idx_q;
  assign cap_err  = (RD_LAT == 0) ? ar_err : err_q;
  assign cap_data = cap_err ? 32'h0 : mem_q[cap_idx];

  // Register array: cleared by reset, byte-masked local writes at any time.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (lw_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lw_strb[b]) begin
          mem_q[lw_addr][8*b +: 8] <= lw_data[8*b +: 8];
        end
      end
    end
  end

  // Read FSM with registered AR/R outputs, busy flag and completed-beat counter.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rd_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            idx_q     <= ar_idx;
            err_q     <= ar_err;
            arready_q <= 1'b0;
            busy_q    <= 1'b1;
            if (RD_LAT == 0) begin
              state_q  <= StResp;
              rvalid_q <= 1'b1;
              rdata_q  <= cap_data;
              rresp_q  <= cap_err ? RespSlvErr : RespOkay;
            end else begin
              state_q <= StWait;
              cnt_q   <= LatInit;
            end
          end else begin
            // Also raises ARREADY on the first cycle after reset release.
            arready_q <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q  <= StResp;
            rvalid_q <= 1'b1;
            rdata_q  <= cap_data;
            rresp_q  <= cap_err ? RespSlvErr : RespOkay;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (r_hs) begin
            state_q   <= StIdle;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            if (rd_count_q != 16'hFFFF) begin
              rd_count_q <= rd_count_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign busy     = busy_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Scoreboard bench for axi_lite_read_slave, run at read latencies 0, 1 and 3.
// A timeline model predicts each response (data, resp, due cycle) into a queue;
// a negedge monitor pops it when RVALID rises and checks per-cycle outputs.
module tb_axi_lite_read_slave;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    logic          areset  = 1'b1;
    logic          arvalid = 1'b0;
    logic [31:0]   araddr  = '0;
    logic          rready  = 1'b0;
    logic          lw_en   = 1'b0;
    logic [IW-1:0] lw_addr = '0;
    logic [31:0]   lw_data = '0;
    logic [3:0]    lw_strb = '0;
    logic          arready_o;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic [1:0]    rresp_o;
    logic          busy_o;
    logic [15:0]   rd_count_o;

    axi_lite_read_slave #(
      .DEPTH  (DEPTH),
      .RD_LAT (LAT)
    ) u_dut (
      .ACLK     (clk),
      .ARESET   (areset),
      .ARVALID  (arvalid),
      .ARADDR   (araddr),
      .ARREADY  (arready_o),
      .RVALID   (rvalid_o),
      .RDATA    (rdata_o),
      .RRESP    (rresp_o),
      .RREADY   (rready),
      .lw_en    (lw_en),
      .lw_addr  (lw_addr),
      .lw_data  (lw_data),
      .lw_strb  (lw_strb),
      .busy     (busy_o),
      .rd_count (rd_count_o)
    );

    typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      int          due;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    logic [31:0]   mem [DEPTH];
    int            cyc      = 0;
    bit            checking = 1'b0;
    bit            in_beat  = 1'b0;
    bit            m_ardy   = 1'b0;
    bit            m_rv     = 1'b0;
    bit            m_busy   = 1'b0;
    bit            m_wait   = 1'b0;
    int            m_due    = 0;
    logic [15:0]   m_cnt    = '0;
    logic [IW-1:0] p_idx    = '0;
    bit            p_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL lat%0d %s at cycle %0d: got %h required %h", LAT, name, cyc, act, req);
      end
    endtask

    // Reference timeline: a read accepted at edge T is captured at edge T+LAT from
    // the array contents before that edge's local write, and held until RREADY.
    always @(posedge clk) begin
      if (areset) begin
        foreach (mem[i]) mem[i] = '0;
        exp_q.delete();
        m_ardy = 1'b0;
        m_rv   = 1'b0;
        m_busy = 1'b0;
        m_wait = 1'b0;
        m_cnt  = '0;
      end else begin
        if (arvalid && m_ardy) begin
          p_idx  = araddr[IW+1:2];
          p_err  = (araddr >= DEPTH * 4);
          m_due  = cyc + int'(LAT);
          m_wait = 1'b1;
        end
        if (m_wait && cyc == m_due) begin
          exp_t e;
          e.data = p_err ? 32'h0 : mem[p_idx];
          e.resp = p_err ? 2'b10 : 2'b00;
          e.due  = cyc;
          exp_q.push_back(e);
          m_wait = 1'b0;
          m_rv   = 1'b1;
        end else if (m_rv && rready) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          m_rv = 1'b0;
        end
        m_busy = m_wait || m_rv;
        m_ardy = !m_busy;
        if (lw_en) begin
          for (int b = 0; b < 4; b++) begin
            if (lw_strb[b]) mem[lw_addr][8*b +: 8] = lw_data[8*b +: 8];
          end
        end
      end
      cyc++;
    end

    // Monitor: per-cycle control outputs, then scoreboard pop on each new R beat.
    always @(negedge clk) begin
      if (checking) begin
        chk("arready", 32'(arready_o), 32'(m_ardy));
        chk("rvalid", 32'(rvalid_o), 32'(m_rv));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("rd_count", 32'(rd_count_o), 32'(m_cnt));
        if (rvalid_o === 1'b1) begin
          if (!in_beat) begin
            in_beat = 1'b1;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL lat%0d unexpected_beat at cycle %0d: got rvalid=1 required no beat",
                       LAT, cyc);
            end else begin
              cur = exp_q.pop_front();
              chk("latency", 32'(cyc), 32'(cur.due + 1));
            end
          end
          chk("rdata", rdata_o, cur.data);
          chk("rresp", 32'(rresp_o), 32'(cur.resp));
        end else begin
          in_beat = 1'b0;
          chk("rdata_idle", rdata_o, 32'h0);
          chk("rresp_idle", 32'(rresp_o), 32'h0);
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic lw(input logic [IW-1:0] idx, input logic [31:0] d, input logic [3:0] s);
      lw_en   = 1'b1;
      lw_addr = idx;
      lw_data = d;
      lw_strb = s;
      tick();
      lw_en   = 1'b0;
      lw_strb = '0;
    endtask

    task automatic wait_ready();
      int n = 0;
      while (!m_ardy && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) begin
        total++;
        bad++;
        $display("FAIL lat%0d wait_ready: got no ready in 50 cycles required ready", LAT);
      end
    endtask

    task automatic wait_rvalid();
      int n = 0;
      while (!m_rv && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) begin
        total++;
        bad++;
        $display("FAIL lat%0d wait_rvalid: got no response in 50 cycles required one", LAT);
      end
    endtask

    // One read; optionally stall RREADY for `hold` cycles, writing the same word first.
    task automatic rd(input logic [31:0] a, input int hold, input bit wr_during);
      wait_ready();
      arvalid = 1'b1;
      araddr  = a;
      rready  = (hold == 0);
      tick();
      arvalid = 1'b0;
      araddr  = $urandom;
      wait_rvalid();
      for (int i = 0; i < hold; i++) begin
        if (wr_during && i == 0) lw(a[IW+1:2], $urandom, 4'hF);
        else tick();
      end
      rready = 1'b1;
      tick();
    endtask

    initial begin
      areset = 1'b1;
      tick();
      checking = 1'b1;
      tick();
      areset = 1'b0;
      tick();

      lw(4'd0, 32'h12345678, 4'hF);
      rd(32'h0, 0, 1'b0);
      lw(4'd3, 32'hAABBCCDD, 4'hF);
      lw(4'd3, 32'h11223344, 4'b0101);
      rd(32'd12, 0, 1'b0);
      rd(32'd13, 0, 1'b0);
      lw(4'd3, 32'hFFFFFFFF, 4'h0);
      rd(32'd12, 0, 1'b0);
      rd(32'h40, 0, 1'b0);
      rd(32'h0, 0, 1'b0);
      rd(32'hFFFF_FFFC, 0, 1'b0);
      rd(32'd12, 5, 1'b1);

      // ARVALID held high: accepted only in IDLE, giving LAT+2 spacing.
      wait_ready();
      arvalid = 1'b1;
      araddr  = 32'd4;
      rready  = 1'b1;
      repeat (4 * (LAT + 2)) tick();
      arvalid = 1'b0;
      repeat (LAT + 3) tick();

      // Reset while waiting for the capture edge.
      lw(4'd2, 32'hDEADBEEF, 4'hF);
      wait_ready();
      arvalid = 1'b1;
      araddr  = 32'd8;
      rready  = 1'b0;
      tick();
      arvalid = 1'b0;
      areset  = 1'b1;
      tick();
      areset  = 1'b0;
      repeat (3) tick();

      // Reset while holding a response.
      lw(4'd2, 32'hCAFEF00D, 4'hF);
      wait_ready();
      arvalid = 1'b1;
      araddr  = 32'd8;
      rready  = 1'b0;
      tick();
      arvalid = 1'b0;
      wait_rvalid();
      tick();
      areset = 1'b1;
      tick();
      areset = 1'b0;
      tick();
      rd(32'd8, 0, 1'b0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 500; i++) begin
        arvalid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) araddr = DEPTH * 4 + $urandom_range(0, 255);
        else araddr = $urandom_range(0, DEPTH * 4 - 1);
        rready  = ($urandom_range(0, 2) != 0);
        lw_en   = ($urandom_range(0, 3) == 0);
        lw_addr = IW'($urandom);
        lw_data = $urandom;
        lw_strb = 4'($urandom);
        areset  = ($urandom_range(0, 120) == 0);
        tick();
      end
      arvalid = 1'b0;
      areset  = 1'b0;
      lw_en   = 1'b0;
      rready  = 1'b1;
      repeat (LAT + 5) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      done++;
    end
  end

  initial begin
    int n = 0;
    while (done < 3 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (done < 3) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d instances finished required 3", done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_read_slave.md
Name: axi_lite_read_slave

Overview:
AXI4-Lite read-channel responder (AR/R) backed by a DEPTH-word register array. It is the read-direction counterpart to the existing write path.
- The array is loaded through a local write port, which keeps the block standalone-testable.
- Its AR and R ports connect directly to the master's ARVALID/ARADDR/ARREADY and RVALID/RDATA/RRESP/RREADY.
- It supports one outstanding read, programmable read latency, and SLVERR on out-of-range addresses.

Parameters:
DEPTH, 16, number of 32-bit words; power of 2, 2..256
RD_LAT, 1, wait cycles between AR handshake and RVALID assertion; 0..15
IW, $clog2(DEPTH), word-index width (derived, not overridden)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  reset, synchronous, active-high
ARVALID  in  1  read address valid
ARADDR  in  32  byte address
ARREADY  out  1  read address ready
RVALID  out  1  read data valid
RDATA  out  32  read data
RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
RREADY  in  1  master ready for read data
lw_en  in  1  local write enable
lw_addr  in  IW  local write word index
lw_data  in  32  local write data
lw_strb  in  4  byte enables; bit i writes byte i
busy  out  1  high in WAIT or RESP
rd_count  out  16  completed R handshakes, saturating

Behaviour:
- Reset (ARESET high at a rising edge):
  - next cycle: ARREADY=0, RVALID=0, RDATA=0, RRESP=0, busy=0, rd_count=0, all array words=0
  - ARREADY goes to 1 in the first cycle after ARESET is sampled low
- Reset mid-transaction: the pending response is dropped with no R beat; the FSM returns to IDLE.
- FSM is IDLE, WAIT, RESP; every output is registered.
- IDLE:
  - ARREADY=1, RVALID=0
  - AR handshake = ARVALID&&ARREADY at an edge; at that edge latch the index ARADDR[IW+1:2] and the error flag (ARADDR >= DEPTH*4)
  - go to WAIT with counter=RD_LAT-1 if RD_LAT>0, else go straight to RESP
  - ARREADY drops to 0 the cycle after the handshake
- WAIT:
  - counter decrements each cycle
  - at 0, go to RESP
- Timing: AR handshake at edge T puts RVALID=1 in the cycle after edge T+RD_LAT.
- Entering RESP:
  - RDATA = array[idx], captured at the entry edge; on error RDATA=0, RRESP=2'b10
  - RDATA and RRESP stay stable while RVALID=1 and RREADY=0
  - a local write during the hold does not change RDATA
- RESP:
  - R handshake = RVALID&&RREADY at an edge
  - at that edge rd_count increments, saturating at 16'hFFFF (SLVERR beats are counted too)
  - next cycle: RVALID=0, ARREADY=1, RDATA and RRESP reset to 0
- Throughput: minimum AR-to-AR spacing is RD_LAT+2 cycles.
- ARADDR[1:0] != 0: address aligned down, RRESP OKAY. ARADDR bits above IW+1 select the error, not wrap-around.
- Local write:
  - applied at the edge when lw_en=1, byte-masked by lw_strb; lw_strb=0 is a no-op
  - allowed in any state
  - if it coincides with the RESP-entry capture edge, RDATA returns the pre-write value
- Index latching: ARVALID is ignored outside IDLE. ARADDR changes after the handshake have no effect.

Test Plan:
- Reset, then local-write 32'h12345678 to word 0 (strb 4'hF), RD_LAT=1, ARADDR=0 with RREADY=1 -> ARREADY=0 next cycle, RVALID at T+2, RDATA=32'h12345678, RRESP=00, rd_count=1.
- Word 3 holds 32'hAABBCCDD; local write 32'h11223344 with strb 4'b0101 -> read of ARADDR=12 returns 32'hAA22CC44; read of ARADDR=13 returns the same, OKAY.
- DEPTH=16, ARADDR=32'h40 -> RVALID with RRESP=10, RDATA=0, rd_count increments; next read of ARADDR=0 is OKAY.
- RREADY held low for 5 cycles after RVALID, with a local write to the same word during the hold -> RDATA/RRESP unchanged for all 5 cycles; one handshake; ARREADY=1 the cycle after.
- RD_LAT=0 and RD_LAT=3 -> RVALID respectively 1 and 4 cycles after the AR edge; ARVALID held high through the response is not accepted again until IDLE, giving RD_LAT+2 cycle spacing.
- ARESET asserted while in WAIT and, separately, in RESP -> RVALID=0 next cycle, no handshake counted, rd_count=0, array cleared, ARREADY=1 the cycle after release.
